// File: rtl/ace_req_arbiter.sv
// rtl/ace_req_arbiter.sv - round-robin arbiter sharing one ACE master controller between cache requesters
//
// Purpose:
//   NUM_REQ cache-side requesters compete for a single ACE master controller.
//   A round-robin winner is latched and issued as a one-cycle read/write/invalid
//   pulse. The grant is held until the controller reports completion, which is
//   returned to the winner as a one-cycle done pulse. A watchdog aborts stuck
//   transactions with an error pulse and a sticky flag.
//
// Ports:
//   clk, rst          clock (posedge), synchronous active-high reset
//   req_valid[i]      request from requester i, held until its done/err
//   req_type[2i+1:2i] 00 read, 01 write, 10 invalid (make-unique), 11 reserved
//   req_addr[i]       request address, ADDR_W bits per requester
//   req_done[i]       one-cycle completion pulse to the granted requester
//   req_err[i]        one-cycle error pulse (reserved type or watchdog abort)
//   read_req          one-cycle read request to the controller
//   write_req         one-cycle write request to the controller
//   invalid_req       one-cycle make-unique request to the controller
//   addr_o            latched address of the granted request
//   ace_ready         controller transaction-complete pulse
//   ac_valid_mon      copy of interconnect AC_VALID (snoop pending)
//   ac_ready_mon      copy of controller AC_READY (controller idle)
//   busy              high while a request is in ISSUE or WAIT
//   grant_id          index of the current or most recent grant
//   timeout_flag      sticky watchdog-abort indicator, cleared only by rst

module ace_req_arbiter #(
    parameter  int NUM_REQ     = 2,
    parameter  int ADDR_W      = 32,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_type,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic                      read_req,
    output logic                      write_req,
    output logic                      invalid_req,
    output logic [ADDR_W-1:0]         addr_o,
    input  logic                      ace_ready,
    input  logic                      ac_valid_mon,
    input  logic                      ac_ready_mon,
    output logic                      busy,
    output logic [GW-1:0]             grant_id,
    output logic                      timeout_flag
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] WD_TERM = CW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] TYPE_READ  = 2'b00;
    localparam logic [1:0] TYPE_WRITE = 2'b01;
    localparam logic [1:0] TYPE_INVAL = 2'b10;
    localparam logic [1:0] TYPE_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [1:0]          type_q;
    logic                err_pend_q;
    logic [GW-1:0]       last_grant_q;
    logic [CW-1:0]       wd_cnt_q;

    logic                win_found;
    logic [GW-1:0]       win_idx;
    logic [1:0]          win_type;
    logic [ADDR_W-1:0]   win_addr;
    logic                issue_ok;
    logic                wd_term;
    logic [NUM_REQ-1:0]  grant_oh;

    // Index 'offs' positions above 'base', wrapping at NUM_REQ.
    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[GW-1:0];
    endfunction

    // Round-robin search starting just above the last grant; the last
    // grant itself is visited last so a lone requester can still win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[rr_index(last_grant_q, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(last_grant_q, k);
            end
        end
    end

    assign win_type = req_type[2*int'(win_idx) +: 2];
    assign win_addr = req_addr[ADDR_W*int'(win_idx) +: ADDR_W];

    // Snoops take precedence: never start a request while one is pending
    // or the controller is still busy. The cycle carrying a reserved-type
    // error pulse belongs to the old request, so no arbitration happens then.
    assign issue_ok = (state_q == ST_IDLE) && !err_pend_q && win_found
                      && ac_ready_mon && !ac_valid_mon;

    assign wd_term  = (wd_cnt_q == WD_TERM);
    assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        read_req    = 1'b0;
        write_req   = 1'b0;
        invalid_req = 1'b0;
        req_done    = '0;
        req_err     = '0;
        busy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (err_pend_q) begin
                    req_err = grant_oh;
                end else if (issue_ok && (win_type != TYPE_RSVD)) begin
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                busy = 1'b1;
                case (type_q)
                    TYPE_READ:  read_req    = 1'b1;
                    TYPE_WRITE: write_req   = 1'b1;
                    TYPE_INVAL: invalid_req = 1'b1;
                    default:    ;
                endcase
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                busy = 1'b1;
                // Completion beats the watchdog when both land together.
                if (ace_ready) begin
                    req_done = grant_oh;
                    state_d  = ST_IDLE;
                end else if (wd_term) begin
                    req_err = grant_oh;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset aborts whatever is in flight without reporting it.
        if (rst) begin
            read_req    = 1'b0;
            write_req   = 1'b0;
            invalid_req = 1'b0;
            req_done    = '0;
            req_err     = '0;
            busy        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type_q       <= TYPE_READ;
            addr_o       <= '0;
            grant_id     <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            err_pend_q   <= 1'b0;
            wd_cnt_q     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            err_pend_q <= 1'b0;

            if (issue_ok) begin
                type_q     <= win_type;
                addr_o     <= win_addr;
                grant_id   <= win_idx;
                err_pend_q <= (win_type == TYPE_RSVD);
            end

            if ((state_q == ST_IDLE) && err_pend_q) begin
                last_grant_q <= grant_id;
            end

            if (state_q == ST_ISSUE) begin
                wd_cnt_q <= '0;
            end

            if (state_q == ST_WAIT) begin
                if (ace_ready) begin
                    last_grant_q <= grant_id;
                end else if (wd_term) begin
                    last_grant_q <= grant_id;
                    timeout_flag <= 1'b1;
                end else begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                end
            end
        end
    end

    a_one_ctrl_pulse: assert property (@(posedge clk) disable iff (rst)
        $onehot0({read_req, write_req, invalid_req}));

    a_one_completion: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_done | req_err));

    a_no_issue_in_snoop: assert property (@(posedge clk) disable iff (rst)
        issue_ok |-> !ac_valid_mon);

endmodule

// File: tb/tb_ace_req_arbiter.sv
// tb/tb_ace_req_arbiter.sv - scoreboard testbench for ace_req_arbiter

module tb_ace_req_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int ADDR_W      = 32;
    localparam int TIMEOUT_CYC = 8;
    localparam int GW          = 1;

    localparam logic [2:0] P_RD  = 3'b001;
    localparam logic [2:0] P_WR  = 3'b010;
    localparam logic [2:0] P_INV = 3'b100;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [2*NUM_REQ-1:0]      req_type;
    logic [ADDR_W*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_err;
    logic                      read_req;
    logic                      write_req;
    logic                      invalid_req;
    logic [ADDR_W-1:0]         addr_o;
    logic                      ace_ready;
    logic                      ac_valid_mon;
    logic                      ac_ready_mon;
    logic                      busy;
    logic [GW-1:0]             grant_id;
    logic                      timeout_flag;

    ace_req_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_type     (req_type),
        .req_addr     (req_addr),
        .req_done     (req_done),
        .req_err      (req_err),
        .read_req     (read_req),
        .write_req    (write_req),
        .invalid_req  (invalid_req),
        .addr_o       (addr_o),
        .ace_ready    (ace_ready),
        .ac_valid_mon (ac_valid_mon),
        .ac_ready_mon (ac_ready_mon),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  t;
        logic [31:0] a;
    } rq_t;

    typedef struct {
        int          gid;
        logic [2:0]  pulse;
        logic [31:0] addr;
    } iss_t;

    typedef struct {
        int          gid;
        bit          is_err;
        logic [31:0] addr;
    } cmp_t;

    rq_t  rq_q[NUM_REQ][$];
    iss_t exp_iss[$];
    cmp_t exp_cmp[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_cnt = 0;
    int issue_cyc = 0;
    int comp_cyc  = 0;
    int ctrl_lat  = 3;
    int present_cyc[NUM_REQ] = '{default: 0};
    int comp_cnt[NUM_REQ]    = '{default: 0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_rq(input int i, input logic [1:0] t, input logic [31:0] a);
        rq_t e;
        e.t = t;
        e.a = a;
        rq_q[i].push_back(e);
    endtask

    task automatic exp_issue(input int gid, input logic [2:0] p, input logic [31:0] a);
        iss_t e;
        e.gid   = gid;
        e.pulse = p;
        e.addr  = a;
        exp_iss.push_back(e);
    endtask

    task automatic exp_comp(input int gid, input bit is_err, input logic [31:0] a);
        cmp_t e;
        e.gid    = gid;
        e.is_err = is_err;
        e.addr   = a;
        exp_cmp.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (n < budget && (exp_iss.size() != 0 || exp_cmp.size() != 0
                              || req_valid != '0 || busy)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 64'(exp_iss.size() + exp_cmp.size()), 0);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Requester agents: present queued requests, advance after done/err.
    initial begin
        rq_t e;
        int  used[NUM_REQ];
        req_valid = '0;
        req_type  = '0;
        req_addr  = '0;
        for (int i = 0; i < NUM_REQ; i++) used[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rst) begin
                    req_valid[i] = 1'b0;
                    used[i] = comp_cnt[i];
                end else if (!req_valid[i] || used[i] != comp_cnt[i]) begin
                    used[i] = comp_cnt[i];
                    if (rq_q[i].size() > 0) begin
                        e = rq_q[i].pop_front();
                        req_type[2*i +: 2]           = e.t;
                        req_addr[ADDR_W*i +: ADDR_W] = e.a;
                        req_valid[i]   = 1'b1;
                        present_cyc[i] = cyc;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Controller model: answers a request pulse ctrl_lat cycles later.
    initial begin
        ace_ready = 1'b0;
        forever begin
            @(negedge clk);
            if ((read_req || write_req || invalid_req) && ctrl_lat > 0) begin
                repeat (ctrl_lat) @(posedge clk);
                #1 ace_ready = 1'b1;
                @(posedge clk);
                #1 ace_ready = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [2:0]         pulse;
        logic [NUM_REQ-1:0] comp;
        bit                 chk_busy;
        iss_t               ei;
        cmp_t               ec;
        chk_busy = 1'b0;
        forever begin
            @(negedge clk);
            pulse = {invalid_req, write_req, read_req};
            comp  = req_done | req_err;
            if (chk_busy) begin
                check("busy_after_done", busy, 0);
                chk_busy = 1'b0;
            end
            if (pulse != 3'b000) begin
                pulse_cnt++;
                issue_cyc = cyc;
                check("issue_in_snoop", ac_valid_mon, 0);
                if (exp_iss.size() == 0) begin
                    check("unexpected_issue", pulse, 0);
                end else begin
                    ei = exp_iss.pop_front();
                    check("issue_kind", pulse, ei.pulse);
                    check("issue_grant", grant_id, ei.gid);
                    check("issue_addr", addr_o, ei.addr);
                end
            end
            if (comp != '0) begin
                comp_cyc = cyc;
                chk_busy = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) if (comp[i]) comp_cnt[i]++;
                if (exp_cmp.size() == 0) begin
                    check("unexpected_completion", comp, 0);
                end else begin
                    ec = exp_cmp.pop_front();
                    check("done_vec", req_done, ec.is_err ? 0 : (1 << ec.gid));
                    check("err_vec", req_err, ec.is_err ? (1 << ec.gid) : 0);
                    check("comp_addr", addr_o, ec.addr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "tb watchdog");
    end

    initial begin
        int pc0;
        int rel;
        int n;
        rst          = 1'b1;
        ac_valid_mon = 1'b0;
        ac_ready_mon = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_addr", addr_o, 0);
        check("rst_pulses", {invalid_req, write_req, read_req}, 0);
        check("rst_done", req_done, 0);
        check("rst_err", req_err, 0);
        check("rst_tflag", timeout_flag, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;

        // Round-robin: both held valid, grants alternate from requester 0
        ctrl_lat = 1;
        push_rq(0, 2'b01, 32'h2000);
        push_rq(0, 2'b01, 32'h2004);
        push_rq(1, 2'b10, 32'h3000);
        push_rq(1, 2'b10, 32'h3004);
        exp_issue(0, P_WR,  32'h2000);
        exp_issue(1, P_INV, 32'h3000);
        exp_issue(0, P_WR,  32'h2004);
        exp_issue(1, P_INV, 32'h3004);
        exp_comp(0, 0, 32'h2000);
        exp_comp(1, 0, 32'h3000);
        exp_comp(0, 0, 32'h2004);
        exp_comp(1, 0, 32'h3004);
        drain("rr", 200);

        // Single read with completion 3 cycles after the pulse
        ctrl_lat = 3;
        push_rq(0, 2'b00, 32'h1000);
        exp_issue(0, P_RD, 32'h1000);
        exp_comp(0, 0, 32'h1000);
        drain("rd", 100);
        check("rd_issue_latency", 64'(issue_cyc - present_cyc[0]), 1);
        check("rd_done_latency", 64'(comp_cyc - issue_cyc), 3);

        // Snoop deferral then controller-busy deferral
        ctrl_lat = 2;
        @(posedge clk);
        #1 ac_valid_mon = 1'b1;
        @(negedge clk);
        #1;
        pc0 = pulse_cnt;
        push_rq(1, 2'b00, 32'h4000);
        exp_issue(1, P_RD, 32'h4000);
        exp_comp(1, 0, 32'h4000);
        repeat (6) @(posedge clk);
        #1;
        check("snoop_defer", 64'(pulse_cnt - pc0), 0);
        ac_valid_mon = 1'b0;
        ac_ready_mon = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ctrl_busy_defer", 64'(pulse_cnt - pc0), 0);
        ac_ready_mon = 1'b1;
        rel = cyc;
        drain("snoop", 100);
        check("snoop_release", 64'(issue_cyc - rel), 1);

        // Reserved type: error pulse, no controller pulse, requester 1 next
        ctrl_lat = 2;
        push_rq(0, 2'b11, 32'h5000);
        push_rq(1, 2'b00, 32'h5100);
        exp_comp(0, 1, 32'h5000);
        exp_issue(1, P_RD, 32'h5100);
        exp_comp(1, 0, 32'h5100);
        drain("rsvd", 100);
        check("rsvd_no_tflag", timeout_flag, 0);

        // Watchdog abort after TIMEOUT_CYC WAIT cycles
        ctrl_lat = -1;
        push_rq(0, 2'b00, 32'h6000);
        exp_issue(0, P_RD, 32'h6000);
        exp_comp(0, 1, 32'h6000);
        drain("to", 100);
        check("to_wait_cycles", 64'(comp_cyc - issue_cyc), TIMEOUT_CYC);
        check("to_flag_set", timeout_flag, 1);

        ctrl_lat = 3;
        push_rq(0, 2'b00, 32'h6100);
        exp_issue(0, P_RD, 32'h6100);
        exp_comp(0, 0, 32'h6100);
        drain("to_after", 100);
        check("to_flag_sticky", timeout_flag, 1);

        // ace_ready on the terminal count wins over the watchdog
        ctrl_lat = TIMEOUT_CYC;
        push_rq(0, 2'b00, 32'h6200);
        exp_issue(0, P_RD, 32'h6200);
        exp_comp(0, 0, 32'h6200);
        drain("to_term", 100);
        check("to_term_cycles", 64'(comp_cyc - issue_cyc), TIMEOUT_CYC);

        // Reset in WAIT: silent abort, outputs cleared, requester 0 first
        ctrl_lat = -1;
        push_rq(1, 2'b01, 32'h7000);
        exp_issue(1, P_WR, 32'h7000);
        n = 0;
        while (exp_iss.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_issue_seen", 64'(exp_iss.size()), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", grant_id, 0);
        check("mid_rst_addr", addr_o, 0);
        check("mid_rst_tflag", timeout_flag, 0);
        check("mid_rst_pulses", {invalid_req, write_req, read_req}, 0);
        #1;
        ctrl_lat = 1;
        push_rq(0, 2'b00, 32'h7100);
        push_rq(1, 2'b00, 32'h7200);
        exp_issue(0, P_RD, 32'h7100);
        exp_issue(1, P_RD, 32'h7200);
        exp_comp(0, 0, 32'h7100);
        exp_comp(1, 0, 32'h7200);
        drain("post_rst", 100);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
